// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states,
// M-extension funct3 codes and operand signedness decode.
package mdu_iter_pkg;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_t;

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

   function automatic logic mdu_op1_signed(input logic [2:0] f);
      return (f == MDU_MUL) || (f == MDU_MULH) || (f == MDU_MULHSU) ||
             (f == MDU_DIV) || (f == MDU_REM);
   endfunction

   function automatic logic mdu_op2_signed(input logic [2:0] f);
      return (f == MDU_MUL) || (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// EX-stage <-> MDU handshake and operand bus.
interface mdu_iter_if #(parameter int XLEN = 32);
   logic            s_valid_i;
   logic            s_stall_i;
   logic            s_flush_i;
   logic [2:0]      s_function_i;
   logic [XLEN-1:0] s_operand1_i;
   logic [XLEN-1:0] s_operand2_i;
   logic            s_finished_o;
   logic [XLEN-1:0] s_result_o;
   logic            s_busy_o;

   modport master (
      output s_valid_i, s_stall_i, s_flush_i, s_function_i, s_operand1_i, s_operand2_i,
      input  s_finished_o, s_result_o, s_busy_o
   );

   modport slave (
      input  s_valid_i, s_stall_i, s_flush_i, s_function_i, s_operand1_i, s_operand2_i,
      output s_finished_o, s_result_o, s_busy_o
   );
endinterface

// File: rtl/mdu_iter_step.sv
// Combinational slice retiring STEP bits: shift-add multiply or restoring divide.
// Accumulator is {hi, lo}; in divide mode the quotient bits are returned separately.
module mdu_step #(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   operand_i,
   input  logic              div_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic [STEP-1:0]   quot_o
);

   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN:0]   ext;
   logic [STEP-1:0] quot;

   // Unrolled STEP radix-2 iterations
   always_comb begin
      hi   = acc_i[2*XLEN-1:XLEN];
      lo   = acc_i[XLEN-1:0];
      ext  = '0;
      quot = '0;
      for (int i = 0; i < STEP; i++) begin
         if (div_i) begin
            ext = {hi, lo[XLEN-1]};
            lo  = {lo[XLEN-2:0], 1'b0};
            if (ext >= {1'b0, operand_i}) begin
               ext  = ext - {1'b0, operand_i};
               quot = STEP'({quot, 1'b1});
            end else begin
               quot = STEP'({quot, 1'b0});
            end
            hi = ext[XLEN-1:0];
         end else begin
            ext = {1'b0, hi} + (lo[0] ? {1'b0, operand_i} : {(XLEN+1){1'b0}});
            lo  = {ext[0], lo[XLEN-1:1]};
            hi  = ext[XLEN:1];
         end
      end
      acc_o  = {hi, lo};
      quot_o = quot;
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: magnitudes are iterated, signs are applied
// on the final BUSY edge; trivial cases can complete straight from IDLE.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STEP         = 1,
   parameter int FAST_SPECIAL = 1
) (
   input logic        s_clk_i,
   input logic        s_reset_i,
   mdu_iter_if.slave  bus
);

   localparam int ITERS = XLEN / STEP;
   localparam int CW    = $clog2(ITERS + 1);
   localparam logic [CW-1:0]   CNT_INIT = CW'(ITERS);
   localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_t        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2:0]        func_q, func_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [2*XLEN-1:0] step_acc, acc_next, fin_full;
   logic [STEP-1:0]   step_quot;
   logic [XLEN-1:0]   a_mag, b_mag, spec_res, fin_lo, fin_hi, sel_res;
   logic              a_neg, b_neg, op_div, ovf, spec_hit;

   mdu_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .div_i     (func_q[2]),
      .acc_o     (step_acc),
      .quot_o    (step_quot)
   );

   // Operand decode, special-case detection and final sign correction
   always_comb begin
      op_div = bus.s_function_i[2];
      a_neg  = mdu_op1_signed(bus.s_function_i) & bus.s_operand1_i[XLEN-1];
      b_neg  = mdu_op2_signed(bus.s_function_i) & bus.s_operand2_i[XLEN-1];
      a_mag  = a_neg ? -bus.s_operand1_i : bus.s_operand1_i;
      b_mag  = b_neg ? -bus.s_operand2_i : bus.s_operand2_i;
      ovf    = ((bus.s_function_i == MDU_DIV) || (bus.s_function_i == MDU_REM)) &&
               (bus.s_operand1_i == MIN_INT) && (bus.s_operand2_i == '1);
      if (op_div && (bus.s_operand2_i == '0)) begin
         spec_hit = 1'b1;
         spec_res = bus.s_function_i[1] ? bus.s_operand1_i : '1;
      end else if (ovf) begin
         spec_hit = 1'b1;
         spec_res = bus.s_function_i[1] ? '0 : MIN_INT;
      end else if (!op_div && ((bus.s_operand1_i == '0) || (bus.s_operand2_i == '0))) begin
         spec_hit = 1'b1;
         spec_res = '0;
      end else begin
         spec_hit = 1'b0;
         spec_res = '0;
      end

      acc_next = step_acc | {{(2*XLEN-STEP){1'b0}}, step_quot};
      fin_full = neg_q ? -acc_next : acc_next;
      fin_lo   = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      fin_hi   = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
      case (func_q)
         MDU_MUL:                          sel_res = fin_full[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU:  sel_res = fin_full[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:                sel_res = fin_lo;
         MDU_REM, MDU_REMU:                sel_res = fin_hi;
         default:                          sel_res = '0;
      endcase
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      func_d   = func_q;
      neg_d    = neg_q;
      result_d = result_q;
      if (bus.s_flush_i) begin
         state_d = MDU_IDLE;
      end else begin
         case (state_q)
            MDU_IDLE: begin
               if (bus.s_valid_i) begin
                  func_d = bus.s_function_i;
                  acc_d  = {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
                  opnd_d = op_div ? b_mag : a_mag;
                  // A zero divisor must leave the quotient all-ones whatever the dividend sign
                  if (op_div) begin
                     neg_d = bus.s_function_i[1] ? a_neg :
                             ((a_neg ^ b_neg) & (bus.s_operand2_i != '0));
                  end else begin
                     neg_d = a_neg ^ b_neg;
                  end
                  if ((FAST_SPECIAL != 0) && spec_hit) begin
                     state_d  = MDU_DONE;
                     result_d = spec_res;
                  end else begin
                     state_d = MDU_BUSY;
                     cnt_d   = CNT_INIT;
                  end
               end else begin
                  state_d = MDU_IDLE;
               end
            end
            MDU_BUSY: begin
               if (!bus.s_valid_i) begin
                  state_d = MDU_IDLE;
               end else begin
                  acc_d = acc_next;
                  cnt_d = cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) begin
                     state_d  = MDU_DONE;
                     result_d = sel_res;
                  end else begin
                     state_d = MDU_BUSY;
                  end
               end
            end
            MDU_DONE: begin
               if (!bus.s_stall_i) begin
                  state_d = MDU_IDLE;
               end else begin
                  state_d = MDU_DONE;
               end
            end
            default: state_d = MDU_IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         state_q  <= MDU_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         func_q   <= MDU_MUL;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         func_q   <= func_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign bus.s_finished_o = (state_q == MDU_DONE);
   assign bus.s_busy_o     = (state_q == MDU_BUSY);
   assign bus.s_result_o   = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: one STEP=1 and one STEP=4 instance share stimulus,
// each scenario checks the instance it targets.
module tb_mdu_iter;
   import mdu_iter_pkg::*;

   typedef struct {
      int          sel;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [2:0]  func = 3'd0;
   logic [31:0] op1 = 32'd0, op2 = 32'd0;
   logic        fin1, fin4, busy1, busy4;
   logic [31:0] res1, res4;
   int          checks = 0;
   int          errors = 0;

   mdu_iter_if #(.XLEN(32)) if1 ();
   mdu_iter_if #(.XLEN(32)) if4 ();

   assign if1.s_valid_i = valid;  assign if4.s_valid_i = valid;
   assign if1.s_stall_i = stall;  assign if4.s_stall_i = stall;
   assign if1.s_flush_i = flush;  assign if4.s_flush_i = flush;
   assign if1.s_function_i = func;  assign if4.s_function_i = func;
   assign if1.s_operand1_i = op1;   assign if4.s_operand1_i = op1;
   assign if1.s_operand2_i = op2;   assign if4.s_operand2_i = op2;
   assign fin1 = if1.s_finished_o;  assign fin4 = if4.s_finished_o;
   assign res1 = if1.s_result_o;    assign res4 = if4.s_result_o;
   assign busy1 = if1.s_busy_o;     assign busy4 = if4.s_busy_o;

   mdu_iter #(.XLEN(32), .STEP(1), .FAST_SPECIAL(1)) u_dut1 (
      .s_clk_i(clk), .s_reset_i(rst), .bus(if1.slave));
   mdu_iter #(.XLEN(32), .STEP(4), .FAST_SPECIAL(1)) u_dut4 (
      .s_clk_i(clk), .s_reset_i(rst), .bus(if4.slave));

   always #5 clk = ~clk;

   function automatic logic fin_of(input int sel);
      return (sel == 4) ? fin4 : fin1;
   endfunction

   function automatic logic [31:0] res_of(input int sel);
      return (sel == 4) ? res4 : res1;
   endfunction

   function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0] up;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      up = {32'd0, a} * {32'd0, b};
      case (f)
         3'd0: return up[31:0];
         3'd1: begin sp = sa * sb; return sp[63:32]; end
         3'd2: begin sp = sa * $signed({32'd0, b}); return sp[63:32]; end
         3'd3: return up[63:32];
         3'd4: if (b == 32'd0) return 32'hFFFFFFFF;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
               else return $signed(a) / $signed(b);
         3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
         3'd6: if (b == 32'd0) return a;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
               else return $signed(a) % $signed(b);
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // Idle both instances, issue one op, scramble inputs once latched, wait for finish
   task automatic do_op(input int sel, input logic [2:0] f, input logic [31:0] a, b,
                        output int lat, output logic [31:0] res);
      valid = 1'b0; stall = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      func = f; op1 = a; op2 = b; valid = 1'b1; stall = 1'b1;
      lat = -1; res = 'x;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 1) begin
            func = 3'($urandom); op1 = $urandom; op2 = $urandom;
         end
         if (fin_of(sel)) begin
            lat = k; res = res_of(sel);
            break;
         end
      end
      stall = 1'b0; valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({fin1, busy1, res1} !== 34'd0) begin
         errors++; $display("FAIL reset_step1: got %h expected 0", {fin1, busy1, res1});
      end
      checks++;
      if ({fin4, busy4, res4} !== 34'd0) begin
         errors++; $display("FAIL reset_step4: got %h expected 0", {fin4, busy4, res4});
      end
   endtask

   task automatic test_mul_stall();
      int lat = -1;
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      func = MDU_MUL; op1 = 32'd7; op2 = 32'hFFFFFFFD; valid = 1'b1; stall = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 2) begin
            checks++;
            if (busy1 !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b expected 1", busy1); end
         end
         if (fin1) begin lat = k; break; end
      end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
      checks++;
      if (res1 !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", res1); end
      for (int k = 0; k < 3; k++) begin
         op1 = $urandom;
         @(negedge clk);
         checks++;
         if ({fin1, busy1, res1} !== {2'b10, 32'hFFFFFFEB}) begin
            errors++; $display("FAIL mul_hold: got %b%b %h expected 10 ffffffeb", fin1, busy1, res1);
         end
      end
      stall = 1'b0; valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({fin1, busy1} !== 2'b00) begin
         errors++; $display("FAIL mul_release: got %b expected 00", {fin1, busy1});
      end
   endtask

   task automatic test_vectors();
      vec_t v[14] = '{
         '{1, MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu"},
         '{1, MDU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu"},
         '{1, MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min"},
         '{1, MDU_MUL,    32'd0,        32'd5,        32'd0,        1,  "mul_zero"},
         '{1, MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_neg"},
         '{1, MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_neg"},
         '{1, MDU_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1,  "divu_zero"},
         '{1, MDU_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  "rem_zero"},
         '{1, MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"},
         '{1, MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf"},
         '{4, MDU_DIVU,   32'h12345678, 32'h10,       32'h01234567, 9,  "divu_s4"},
         '{4, MDU_REMU,   32'h12345678, 32'h10,       32'h8,        9,  "remu_s4"},
         '{4, MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 9,  "mul_s4"},
         '{4, MDU_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 9,  "div_s4"}
      };
      int lat;
      logic [31:0] res;
      foreach (v[i]) begin
         do_op(v[i].sel, v[i].f, v[i].a, v[i].b, lat, res);
         checks++;
         if (lat !== v[i].lat) begin
            errors++; $display("FAIL %s_latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
         end
         checks++;
         if (res !== v[i].exp) begin
            errors++; $display("FAIL %s_result: got %h expected %h", v[i].name, res, v[i].exp);
         end
      end
   endtask

   task automatic test_flush();
      logic seen = 1'b0;
      int lat = -1;
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      func = MDU_DIV; op1 = 32'd100; op2 = 32'd7; valid = 1'b1; stall = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         seen = seen | fin1;
      end
      flush = 1'b1;
      @(negedge clk);
      seen = seen | fin1;
      checks++;
      if ({seen, busy1} !== 2'b00) begin
         errors++; $display("FAIL flush_abort: got %b expected 00", {seen, busy1});
      end
      flush = 1'b0; func = MDU_MUL; op1 = 32'd3; op2 = 32'd5;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (fin1) begin lat = k; break; end
      end
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL flush_next_latency: got %0d expected 33", lat); end
      checks++;
      if (res1 !== 32'd15) begin errors++; $display("FAIL flush_next_result: got %h expected f", res1); end
      stall = 1'b0; valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [31:0] res;
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      func = MDU_DIVU; op1 = 32'd1000; op2 = 32'd3; valid = 1'b1; stall = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; valid = 1'b0; stall = 1'b0;
      checks++;
      if ({fin1, busy1, res1, fin4, busy4, res4} !== 68'd0) begin
         errors++; $display("FAIL reset_mid: got %b%b %h %b%b %h expected all 0",
                            fin1, busy1, res1, fin4, busy4, res4);
      end
      do_op(1, MDU_MUL, 32'd2, 32'd2, lat, res);
      checks++;
      if ({lat, res} !== {32'd33, 32'd4}) begin
         errors++; $display("FAIL reset_mul_s1: got lat %0d res %h expected 33 4", lat, res);
      end
      do_op(4, MDU_MUL, 32'd2, 32'd2, lat, res);
      checks++;
      if ({lat, res} !== {32'd9, 32'd4}) begin
         errors++; $display("FAIL reset_mul_s4: got lat %0d res %h expected 9 4", lat, res);
      end
   endtask

   task automatic test_random();
      logic [31:0] corner[4] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
      logic [31:0] a, b, exp;
      logic [2:0]  f;
      int lat;
      logic [31:0] res;
      for (int n = 0; n < 50; n++) begin
         f = 3'($urandom);
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         exp = ref_mdu(f, a, b);
         do_op((n < 25) ? 1 : 4, f, a, b, lat, res);
         checks++;
         if (res !== exp) begin
            errors++; $display("FAIL random_f%0d: %h op %h got %h expected %h", f, a, b, res, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_stall();
      test_vectors();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
